// File: rtl/le18_pkg.sv
// Shared constants and types for the LE18 graphics RAM port-A arbiter.
package le18_pkg;

  localparam int LE18_AW   = 14;
  localparam int LE18_DW   = 6;
  localparam int LE18_COLS = 64;
  localparam int LE18_ROWS = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } le18_fill_state_t;

endpackage

// File: rtl/le18_fill_seq.sv
// Fill engine: walks {row, col} from {y0, 0} to {y1, 63}, one word per granted cycle.
module le18_fill_seq
  import le18_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [LE18_DW-1:0]   value_i,
  input  logic [7:0]           y0_i,
  input  logic [7:0]           y1_i,
  input  logic                 grant_i,
  output logic                 req_o,
  output logic [LE18_AW-1:0]   addr_o,
  output logic [LE18_DW-1:0]   data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output le18_fill_state_t     state_o
);

  localparam logic [5:0] LAST_COL = 6'(LE18_COLS - 1);

  le18_fill_state_t     state_q;
  logic [LE18_AW-1:0]   cnt_q;
  logic [LE18_DW-1:0]   val_q;
  logic [7:0]           y1_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 start_now;
  logic                 last_word;

  // The first word is offered straight from the start inputs so it can be
  // written the cycle after fill_start.
  always_comb begin
    start_now = (state_q == IDLE) && start_i;
    req_o     = (state_q == FILL) || start_now;
    addr_o    = start_now ? {y0_i, 6'd0} : cnt_q;
    data_o    = start_now ? value_i : val_q;
    last_word = (state_q == FILL) && (cnt_q == {y1_q, LAST_COL});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      y1_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            val_q   <= value_i;
            y1_q    <= y1_i;
            cnt_q   <= grant_i ? ({y0_i, 6'd0} + 1'b1) : {y0_i, 6'd0};
            state_q <= FILL;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          if (grant_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_word) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: rtl/le18_mem_arbiter.sv
// LE18 RAM port-A arbiter: Z80 write > Z80 read > fill write > idle.
// Fill engine compiled in only when LE18_FILL_EN is defined.
module le18_mem_arbiter
  import le18_pkg::*;
#(
  parameter int AW = LE18_AW,
  parameter int DW = LE18_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          z80_rd_req,
  input  logic          z80_wr_req,
  input  logic [AW-1:0] z80_addr,
  input  logic [DW-1:0] z80_wdata,
  output logic [DW-1:0] z80_rdata,
  output logic          z80_rdy,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  input  logic [7:0]    fill_y0,
  input  logic [7:0]    fill_y1,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          mem_ce,
  output logic          mem_we,
  output logic          mem_oce,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  logic          fill_req;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;

  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_gnt_q;
  logic          mem_ce_q, mem_ce_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_oce_q;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          rdy_q;
  logic [DW-1:0] rdata_q;
  logic          gnt_wr, gnt_rd, gnt_fill;

  // A write request is always granted the cycle it arrives, so only a read
  // (beaten by a simultaneous write) ever has to wait in a pending flag.
  always_comb begin
    rd_addr_d  = z80_rd_req ? z80_addr : rd_addr_q;
    gnt_wr     = z80_wr_req;
    gnt_rd     = (rd_pend_q || z80_rd_req) && !gnt_wr;
    gnt_fill   = fill_req && !gnt_wr && !(rd_pend_q || z80_rd_req) && !rd_gnt_q;
    rd_pend_d  = (rd_pend_q || z80_rd_req) && !gnt_rd;
    mem_ce_d   = gnt_wr || gnt_rd || gnt_fill;
    mem_we_d   = gnt_wr || gnt_fill;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (gnt_wr) begin
      mem_addr_d = z80_addr;
      mem_din_d  = z80_wdata;
    end else if (gnt_rd) begin
      mem_addr_d = rd_addr_d;
    end else if (gnt_fill) begin
      mem_addr_d = fill_addr;
      mem_din_d  = fill_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_gnt_q   <= 1'b0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_oce_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdy_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      rd_gnt_q   <= gnt_rd;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      mem_oce_q  <= rd_gnt_q;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdy_q      <= mem_oce_q;
      if (rdy_q) rdata_q <= mem_dout;
    end
  end

  // RAM output register is valid in the rdy cycle itself; show it directly
  // then, and hold the captured copy afterwards.
  assign z80_rdata = rdy_q ? mem_dout : rdata_q;
  assign z80_rdy   = rdy_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_oce   = mem_oce_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

`ifdef LE18_FILL_EN
  le18_fill_state_t fill_state_unused;

  le18_fill_seq u_fill_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (fill_start),
    .value_i (fill_value),
    .y0_i    (fill_y0),
    .y1_i    (fill_y1),
    .grant_i (gnt_fill),
    .req_o   (fill_req),
    .addr_o  (fill_addr),
    .data_o  (fill_data),
    .busy_o  (fill_busy),
    .done_o  (fill_done),
    .state_o (fill_state_unused)
  );
`else
  logic unused_fill;
  assign fill_req    = 1'b0;
  assign fill_addr   = '0;
  assign fill_data   = '0;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
  assign unused_fill = ^{fill_start, fill_value, fill_y0, fill_y1, gnt_fill};
`endif

endmodule

// File: tb/tb_le18_mem_arbiter.sv
// Bench for le18_mem_arbiter: random Z80 traffic and fills against a queue scoreboard.
module tb_le18_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        z80_rd_req = 1'b0, z80_wr_req = 1'b0;
  logic [13:0] z80_addr = '0;
  logic [5:0]  z80_wdata = '0, z80_rdata;
  logic        z80_rdy;
  logic        fill_start = 1'b0;
  logic [5:0]  fill_value = '0;
  logic [7:0]  fill_y0 = '0, fill_y1 = '0;
  logic        fill_busy, fill_done;
  logic        mem_ce, mem_we, mem_oce;
  logic [13:0] mem_addr;
  logic [5:0]  mem_din, mem_dout = '0;

  le18_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .z80_rd_req(z80_rd_req), .z80_wr_req(z80_wr_req), .z80_addr(z80_addr),
    .z80_wdata(z80_wdata), .z80_rdata(z80_rdata), .z80_rdy(z80_rdy),
    .fill_start(fill_start), .fill_value(fill_value), .fill_y0(fill_y0), .fill_y1(fill_y1),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_oce(mem_oce), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // clock / cycle counter
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port A with output register: dout valid the cycle after oce
  logic [5:0] ram [0:16383];
  logic [5:0] ram_lat = '0;
  always @(posedge clk) begin
    if (mem_ce && mem_we) ram[mem_addr] <= mem_din;
    if (mem_ce && !mem_we) ram_lat <= ram[mem_addr];
    if (mem_oce) mem_dout <= ram_lat;
  end

  // reference model and scoreboard state
  logic [5:0]  ref_mem [0:16383];
  logic [5:0]  exp_q[$];
  int          exp_cyc_q[$];
  logic [13:0] rdbus_addr_q[$];
  int          rdbus_cyc_q[$];
  logic [19:0] zw_q[$];
  int          zw_cyc_q[$];
  logic [19:0] fill_q[$];
  int compared = 0, mismatched = 0;
  int fill_wr_count = 0, last_fill_cyc = 0, done_count = 0, done_cyc = 0;
  logic [13:0] last_fill_addr = '0;
  bit   fill_active = 0, first_pending = 0;
  int   first_exp_cyc = 0;
  int   junk_i;
  logic [19:0] junk_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // monitor: pops and compares whenever the DUT presents something
  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        check("rdy_missing", 0, 1);
        junk_i = exp_cyc_q.pop_front();
        junk_l = 20'(exp_q.pop_front());
      end
      if (z80_rdy) begin
        if (exp_q.size() == 0) check("rdy_unexpected", 1, 0);
        else begin
          check("rd_data", z80_rdata, exp_q.pop_front());
          check("rd_latency", cyc, exp_cyc_q.pop_front());
        end
      end
      if (rdbus_cyc_q.size() > 0 && rdbus_cyc_q[0] < cyc) begin
        check("rd_grant_missing", 0, 1);
        junk_i = rdbus_cyc_q.pop_front();
        junk_l = 20'(rdbus_addr_q.pop_front());
      end
      if (mem_ce && !mem_we) begin
        if (rdbus_addr_q.size() == 0) check("rd_grant_unexpected", 1, 0);
        else begin
          check("rd_grant_addr", mem_addr, rdbus_addr_q.pop_front());
          check("rd_grant_cyc", cyc, rdbus_cyc_q.pop_front());
        end
      end
      if (zw_cyc_q.size() > 0 && zw_cyc_q[0] < cyc) begin
        check("z80_wr_missing", 0, 1);
        junk_i = zw_cyc_q.pop_front();
        junk_l = zw_q.pop_front();
      end
      if (mem_ce && mem_we) begin
        if (zw_cyc_q.size() > 0 && zw_cyc_q[0] == cyc) begin
          check("z80_wr", {mem_addr, mem_din}, zw_q.pop_front());
          junk_i = zw_cyc_q.pop_front();
        end else begin
          check("fill_in_oce_cycle", mem_oce, 0);
          fill_wr_count++;
          last_fill_cyc  = cyc;
          last_fill_addr = mem_addr;
          if (fill_q.size() == 0) check("fill_unexpected", 1, 0);
          else check("fill_wr", {mem_addr, mem_din}, fill_q.pop_front());
          if (first_pending) begin
            check("fill_first_latency", cyc, first_exp_cyc);
            first_pending = 0;
          end
        end
      end
      if (fill_done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic z80_write(input logic [13:0] a, input logic [5:0] d);
    z80_wr_req = 1'b1; z80_addr = a; z80_wdata = d;
    zw_q.push_back({a, d}); zw_cyc_q.push_back(cyc + 1);
    ref_mem[a] = d;
    tick();
    z80_wr_req = 1'b0;
  endtask

  task automatic z80_read(input logic [13:0] a);
    z80_rd_req = 1'b1; z80_addr = a;
    rdbus_addr_q.push_back(a); rdbus_cyc_q.push_back(cyc + 1);
    exp_q.push_back(ref_mem[a]); exp_cyc_q.push_back(cyc + 3);
    tick();
    z80_rd_req = 1'b0;
  endtask

  task automatic z80_pair(input logic [13:0] a, input logic [5:0] d);
    z80_wr_req = 1'b1; z80_rd_req = 1'b1; z80_addr = a; z80_wdata = d;
    zw_q.push_back({a, d}); zw_cyc_q.push_back(cyc + 1);
    ref_mem[a] = d;
    rdbus_addr_q.push_back(a); rdbus_cyc_q.push_back(cyc + 2);
    exp_q.push_back(d); exp_cyc_q.push_back(cyc + 4);
    tick();
    z80_wr_req = 1'b0; z80_rd_req = 1'b0;
  endtask

  task automatic rand_op(input int ylo, input int yhi);
    logic [13:0] a;
    logic [5:0]  d;
    int k;
    a = {8'($urandom_range(yhi, ylo)), 6'($urandom_range(63, 0))};
    d = 6'($urandom_range(63, 0));
    k = $urandom_range(2, 0);
    case (k)
      0:       z80_write(a, d);
      1:       z80_read(a);
      default: z80_pair(a, d);
    endcase
    repeat ($urandom_range(4, 1)) tick();
  endtask

  task automatic fill_go(input logic [7:0] y0, input logic [7:0] y1, input logic [5:0] v);
    logic [13:0] a;
    int nrows;
    fill_start = 1'b1; fill_y0 = y0; fill_y1 = y1; fill_value = v;
`ifdef LE18_FILL_EN
    if (!fill_active) begin
      nrows = int'(8'(y1 - y0)) + 1;
      for (int r = 0; r < nrows; r++)
        for (int c = 0; c < 64; c++) begin
          a = {8'(int'(y0) + r), 6'(c)};
          fill_q.push_back({a, v});
          ref_mem[a] = v;
        end
      fill_active   = 1;
      first_pending = 1;
      first_exp_cyc = cyc + 1;
    end
`endif
    tick();
    fill_start = 1'b0;
  endtask

  task automatic flush();
    exp_q.delete(); exp_cyc_q.delete();
    rdbus_addr_q.delete(); rdbus_cyc_q.delete();
    zw_q.delete(); zw_cyc_q.delete(); fill_q.delete();
    first_pending = 0;
    fill_active   = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    @(negedge clk);
    check(name, {z80_rdata, z80_rdy, fill_busy, fill_done, mem_ce, mem_we, mem_oce,
                 mem_addr, mem_din}, 32'd0);
  endtask

`ifdef LE18_FILL_EN
  task automatic wait_fill_done(input int exp_words, input int w0);
    int n0;
    int k;
    n0 = done_count;
    k  = 0;
    while (done_count == n0 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("fill_done_seen", done_count - n0, 1);
    check("fill_done_timing", ((done_cyc - last_fill_cyc) <= 1) ? 1 : 0, 1);
    check("fill_all_written", fill_q.size(), 0);
    check("fill_word_count", fill_wr_count - w0, exp_words);
    @(negedge clk);
    check("fill_busy_clear", fill_busy, 0);
    fill_active = 0;
    tick();
  endtask

  task automatic run_fill(input logic [7:0] y0, input logic [7:0] y1, input logic [5:0] v,
                          input int exp_words, input logic [13:0] exp_last);
    int w0;
    w0 = fill_wr_count;
    fill_go(y0, y1, v);
    @(negedge clk);
    check("fill_busy_set", fill_busy, 1);
    wait_fill_done(exp_words, w0);
    check("fill_last_addr", last_fill_addr, exp_last);
  endtask
`endif

  initial begin
    int w0;
    int d0;
    for (int i = 0; i < 16384; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    check_outputs_zero("reset_outputs");
    tick();
    reset_n = 1'b1;
    tick();

    // directed: write then read back; simultaneous read/write
    z80_write(14'h0041, 6'h2A);
    z80_read(14'h0041);
    repeat (6) tick();
    z80_pair(14'h1000, 6'h15);
    repeat (6) tick();

    // random Z80 traffic on a small address window
    for (int i = 0; i < 40; i++) rand_op(0, 3);
    repeat (8) tick();

`ifdef LE18_FILL_EN
    run_fill(8'd0, 8'd191, 6'h3F, 12288, 14'h2FFF);
    run_fill(8'd254, 8'd1, 6'h00, 256, 14'h007F);

    // Z80 traffic in the middle of a fill, plus an ignored second start
    w0 = fill_wr_count;
    fill_go(8'd10, 8'd20, 6'h2B);
    repeat (3) tick();
    for (int i = 0; i < 15; i++) rand_op(100, 101);
    fill_go(8'd50, 8'd60, 6'h01);
    for (int i = 0; i < 5; i++) rand_op(100, 101);
    wait_fill_done(704, w0);
`else
    d0 = done_count;
    fill_go(8'd0, 8'd3, 6'h3F);
    repeat (40) tick();
    @(negedge clk);
    check("fill_busy_off", fill_busy, 0);
    check("fill_done_off", done_count - d0, 0);
    tick();
`endif

    // reset during a read: no rdy afterwards
    z80_read(14'h0041);
    reset_n = 1'b0;
    flush();
    check_outputs_zero("reset_mid_read");
    tick();
    reset_n = 1'b1;
    repeat (8) tick();

    // reset during a fill: abandoned with no fill_done
    d0 = done_count;
    fill_go(8'd0, 8'd191, 6'h11);
    repeat (200) tick();
    reset_n = 1'b0;
    flush();
    check_outputs_zero("reset_mid_fill");
    tick();
    reset_n = 1'b1;
    repeat (30) tick();
    check("no_done_after_reset", done_count - d0, 0);
    z80_write(14'h0123, 6'h07);
    z80_read(14'h0123);

    // drain, bounded
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0 && rdbus_addr_q.size() == 0 && zw_q.size() == 0 && fill_q.size() == 0)
        break;
      tick();
    end
    check("drain_rdy_q", exp_q.size(), 0);
    check("drain_rdbus_q", rdbus_addr_q.size(), 0);
    check("drain_zw_q", zw_q.size(), 0);
    check("drain_fill_q", fill_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/le18_mem_arbiter.md
# le18_mem_arbiter

Arbitrates the Z80-side port A of the 16384×6 LE18 graphics RAM between Z80 IN/OUT accesses to port 0xEC and a hardware fill engine. It clears or fills a row range of the LE18 bitmap with one value. It sits between the port-0xEC decode triggers and the RAM's A port, and drives that port's `ce`/`we`/`oce` pins. Z80 accesses always win and have a fixed latency. Fill writes use every otherwise idle cycle.

## Interface
Parameters:
- `AW`, 14: RAM address width, `{y[7:0], x[5:0]}`.
- `DW`, 6: RAM data width.

Ports:
- `clk`, in, 1: 100 MHz system clock; the only clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `z80_rd_req`, in, 1: one-cycle pulse requesting a read at `z80_addr`.
- `z80_wr_req`, in, 1: one-cycle pulse requesting a write of `z80_wdata` to `z80_addr`.
- `z80_addr`, in, AW: Z80 address, `{y_reg, x_reg}`.
- `z80_wdata`, in, DW: Z80 write data.
- `z80_rdata`, out, DW: read data; held until the next read completes.
- `z80_rdy`, out, 1: one-cycle pulse; `z80_rdata` is valid.
- `fill_start`, in, 1: one-cycle pulse that starts a fill.
- `fill_value`, in, DW: fill data; sampled at `fill_start`.
- `fill_y0`, in, 8: first row, inclusive; sampled at `fill_start`.
- `fill_y1`, in, 8: last row, inclusive; sampled at `fill_start`.
- `fill_busy`, out, 1: a fill is in progress.
- `fill_done`, out, 1: one-cycle pulse after the last fill write.
- `mem_ce`, out, 1: RAM port A chip enable.
- `mem_we`, out, 1: RAM port A write enable.
- `mem_oce`, out, 1: RAM port A output-register clock enable.
- `mem_addr`, out, AW: RAM port A address.
- `mem_din`, out, DW: RAM port A write data.
- `mem_dout`, in, DW: RAM port A read data, valid the cycle after `mem_oce`.

## Operation
- All outputs are registered. On reset, every output is 0, the fill FSM goes to IDLE, and the pending flags clear.
- Grant priority per cycle, highest first:
  1. pending Z80 write;
  2. pending Z80 read;
  3. fill write;
  4. idle.
- Incoming request pulses set a pending flag (`wr_pend` or `rd_pend`) and latch the address and data. The flag clears when the request is granted.
- If `z80_rd_req` and `z80_wr_req` arrive in the same cycle, both flags set. The write is granted first, then the read on the next cycle.
- A new pulse of a type whose flag is already set overwrites the latched address/data. Only one access of that type is performed.
- Read grant: `mem_ce`=1, `mem_we`=0. Next cycle: `mem_oce`=1. The cycle after that: capture `mem_dout` into `z80_rdata` and pulse `z80_rdy`.
- Fill writes are inhibited in the cycle `mem_oce` is high. Z80 writes are not inhibited.
- Fill FSM states:
  - IDLE → FILL on `fill_start`: latch value, y0, y1; set row/column counter to `{y0, 6'd0}`; `fill_busy`=1.
  - FILL: on each fill grant, write `fill_value` at the counter, then increment it. The column wraps 63 → 0 and carries into the row; the row wraps 255 → 0.
  - FILL → DONE when the write at `{y1, 6'd63}` is granted.
  - DONE → IDLE after one cycle. `fill_done` pulses during DONE; `fill_busy` drops entering DONE.
- Ranges with `y1 < y0` wrap: rows y0..255, then 0..y1. `y0 == y1` fills a single row of 64 words.
- `fill_start` while not in IDLE is ignored. No abort exists; only `reset_n` stops a fill.

## Timing
- Request pulse at cycle t → `wr_pend`/`rd_pend` set at t+1 → RAM grant (`mem_ce`) at t+1 at the earliest.
- Read, uncontended: `mem_ce` at t+1, `mem_oce` at t+2, `z80_rdy` and `z80_rdata` at t+3.
- Read behind a simultaneous write: every read milestone shifts by +1 cycle.
- Worst-case Z80 read latency is 4 cycles (40 ns), well inside the TRS IN wait window.
- Fill throughput is one word per cycle when uncontended. A full 192-row screen (12288 words) takes ≥12288 cycles.
- `fill_start` at t → first fill write at t+1 at the earliest.
- Reset asserted mid-read: no `z80_rdy`. Reset mid-fill: the fill is abandoned and no `fill_done` is issued.

## Configuration
- `LE18_FILL_EN` defined: fill engine compiled in, as described above.
- Undefined: the fill FSM and counters are removed. `fill_busy` and `fill_done` are tied to 0, and `fill_start`, `fill_value`, `fill_y0`, `fill_y1` are ignored. Z80 arbitration and timing are unchanged.

## Structure
- Shared package `le18_pkg`:
  - constants `LE18_AW`=14, `LE18_DW`=6, `LE18_COLS`=64, `LE18_ROWS`=256;
  - fill FSM state type `le18_fill_state_t` = {IDLE, FILL, DONE}.
- One sub-module, `le18_fill_seq`:
  - contains the fill FSM and address counter;
  - interface: a grant input; outputs for request, address, data, busy, done;
  - instantiated only under `LE18_FILL_EN`.
- The arbiter, pending flags and read pipeline stay in the top module.

## Test plan
- Reset, then `z80_wr_req` with addr 0x0041, data 0x2A, followed by `z80_rd_req` at the same address: `mem_ce`/`mem_we` at t+1; `z80_rdy` 3 cycles after the read request, with `z80_rdata`=0x2A.
- `z80_rd_req` and `z80_wr_req` in the same cycle at addr 0x1000, wdata 0x15: write granted at t+1, read granted at t+2, `z80_rdy` at t+4 with data 0x15.
- Fill with y0=0, y1=191, value 0x3F, no Z80 traffic: exactly 12288 writes with consecutive addresses 0x0000..0x2FFF; `fill_done` one cycle after the last write; `fill_busy` cleared.
- Fill with y0=254, y1=1, value 0x00: exactly 256 writes; the address wraps 0x3FFF → 0x0000; the last write goes to 0x007F.
- Z80 read issued mid-fill: no fill write in the `mem_oce` cycle; the fill resumes at the next address with none skipped; the read returns in 3 cycles.
- Second `fill_start` during a fill is ignored, and `reset_n` low mid-fill drives all outputs to 0 with no `fill_done`.
